// File: rtl/hawk_arb_pkg.sv
// hawk_arb_pkg: shared types for the HACD transaction arbiter.
// Holds the FSM state enum, the arbitration mode codes and a width helper.
package hawk_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/hawk_arb_if.sv
// hawk_arb_if: requester-side and server-side handshake bundle.
// master = arbiter view, slave = environment (requesters + server) view.
interface hawk_arb_if #(
  parameter int N_IN  = 2,
  parameter int REQ_W = 64,
  parameter int RSP_W = 64
);

  logic [N_IN-1:0]            req_valid_i;
  logic [N_IN-1:0][REQ_W-1:0] req_data_i;
  logic [N_IN-1:0]            req_ready_o;

  logic                       out_valid_o;
  logic [REQ_W-1:0]           out_data_o;
  logic                       out_ready_i;

  logic                       srv_rsp_valid_i;
  logic [RSP_W-1:0]           srv_rsp_data_i;

  logic [N_IN-1:0]            rsp_valid_o;
  logic [N_IN-1:0][RSP_W-1:0] rsp_data_o;
  logic [N_IN-1:0]            rsp_err_o;

  modport master (
    input  req_valid_i,
    input  req_data_i,
    output req_ready_o,
    output out_valid_o,
    output out_data_o,
    input  out_ready_i,
    input  srv_rsp_valid_i,
    input  srv_rsp_data_i,
    output rsp_valid_o,
    output rsp_data_o,
    output rsp_err_o
  );

  modport slave (
    output req_valid_i,
    output req_data_i,
    input  req_ready_o,
    input  out_valid_o,
    input  out_data_o,
    output out_ready_i,
    output srv_rsp_valid_i,
    output srv_rsp_data_i,
    input  rsp_valid_o,
    input  rsp_data_o,
    input  rsp_err_o
  );

endinterface

// File: rtl/hawk_rr_pick.sv
// hawk_rr_pick: combinational picker, round-robin from ptr_i or lowest index.
// Ports: valid_i/ptr_i/mode_i in; any_o (some valid) and idx_o (winner) out.
module hawk_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          mode_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    j     = 0;
    idx_o = '0;
    any_o = |valid_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (mode_i) j = k;
      else        j = (int'(ptr_i) + k) % N;
      if (valid_i[IW'(j)]) idx_o = IW'(j);
    end
  end

endmodule

// File: rtl/hawk_txn_arbiter.sv
// hawk_txn_arbiter: N-to-1 request/response arbiter with response timeout.
// Ports: clk_i, rst_i (sync high), bus (hawk_arb_if.master), grant/busy/unexp.
module hawk_txn_arbiter
  import hawk_arb_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int REQ_W   = 64,
  parameter int RSP_W   = 64,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 256,
  localparam int IDX_W  = idx_width(N_IN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  hawk_arb_if.master       bus,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             busy_o,
  output logic             unexp_rsp_o
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_M1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             gnt_valid;
  logic             to_hit;
  logic [IDX_W-1:0] nxt_ptr;

  logic [N_IN-1:0]            req_ready;
  logic                       out_valid;
  logic [REQ_W-1:0]           out_data;
  logic [N_IN-1:0]            rsp_valid;
  logic [N_IN-1:0][RSP_W-1:0] rsp_data;
  logic [N_IN-1:0]            rsp_err;

  hawk_rr_pick #(
    .N  (N_IN),
    .IW (IDX_W)
  ) u_pick (
    .valid_i (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .mode_i  (MODE == ARB_FIXED),
    .any_o   (pick_any),
    .idx_o   (pick_idx)
  );

  assign gnt_valid = bus.req_valid_i[grant_q];
  assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign nxt_ptr   = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A withdrawn request leaves ptr alone so it keeps its turn.
        if (!gnt_valid) begin
          state_d = S_IDLE;
        end else if (bus.out_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (bus.srv_rsp_valid_i || to_hit) begin
          state_d = S_IDLE;
          ptr_d   = nxt_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = '0;
    unique case (state_q)
      S_REQ: begin
        // Gated by the granted valid so a withdrawn beat never handshakes.
        out_valid          = gnt_valid;
        out_data           = bus.req_data_i[grant_q];
        req_ready[grant_q] = bus.out_ready_i & gnt_valid;
      end
      S_WAIT: begin
        // A real response beats a timeout on the same cycle.
        if (bus.srv_rsp_valid_i) begin
          rsp_valid[grant_q] = 1'b1;
          rsp_data[grant_q]  = bus.srv_rsp_data_i;
        end else if (to_hit) begin
          rsp_valid[grant_q] = 1'b1;
          rsp_err[grant_q]   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready_o = req_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_err_o   = rsp_err;

  assign grant_idx_o = grant_q;
  assign busy_o      = (state_q != S_IDLE);
  assign unexp_rsp_o = bus.srv_rsp_valid_i && (state_q != S_WAIT);

endmodule

// File: tb/tb_hawk_txn_arbiter.sv
// tb_hawk_txn_arbiter: directed bench for round-robin and fixed-priority arbiters.
// Drives two 4-input instances (TIMEOUT=8) from one linear initial block.
module tb_hawk_txn_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b;
  logic       unexp_a, unexp_b;
  int         ncmp = 0;
  int         nbad = 0;
  logic [63:0] e;

  always #5 clk = ~clk;

  hawk_arb_if #(.N_IN(4), .REQ_W(16), .RSP_W(16)) ifa ();
  hawk_arb_if #(.N_IN(4), .REQ_W(16), .RSP_W(16)) ifb ();

  hawk_txn_arbiter #(
    .N_IN(4), .REQ_W(16), .RSP_W(16), .MODE(0), .TIMEOUT(8)
  ) dut_rr (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (ifa),
    .grant_idx_o (grant_a),
    .busy_o      (busy_a),
    .unexp_rsp_o (unexp_a)
  );

  hawk_txn_arbiter #(
    .N_IN(4), .REQ_W(16), .RSP_W(16), .MODE(1), .TIMEOUT(8)
  ) dut_fx (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (ifb),
    .grant_idx_o (grant_b),
    .busy_o      (busy_b),
    .unexp_rsp_o (unexp_b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.req_valid_i     = '0;
    ifa.out_ready_i     = 1'b0;
    ifa.srv_rsp_valid_i = 1'b0;
    ifa.srv_rsp_data_i  = '0;
    ifb.req_valid_i     = '0;
    ifb.out_ready_i     = 1'b0;
    ifb.srv_rsp_valid_i = 1'b0;
    ifb.srv_rsp_data_i  = '0;
    for (int i = 0; i < 4; i++) begin
      ifa.req_data_i[i] = 16'h00A0 + 16'(i);
      ifb.req_data_i[i] = 16'h00C0 + 16'(i);
    end

    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_grant", grant_a, 0);
    chk("rst_oval", ifa.out_valid_o, 0);
    chk("rst_rdy", ifa.req_ready_o, 0);
    chk("rst_rval", ifa.rsp_valid_o, 0);
    chk("rst_rerr", ifa.rsp_err_o, 0);
    chk("rst_unexp", unexp_a, 0);
    chk("rst_busy_b", busy_b, 0);

    ifb.req_valid_i = 4'b1010;
    ifb.out_ready_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("fx_grant", grant_b, 1);
      chk("fx_rdy", ifb.req_ready_o, 4'b0010);
      step();
      ifb.srv_rsp_valid_i = 1'b1;
      ifb.srv_rsp_data_i  = 16'h0050 + 16'(t);
      #1;
      chk("fx_rval", ifb.rsp_valid_o, 4'b0010);
      step();
      ifb.srv_rsp_valid_i = 1'b0;
    end
    ifb.req_valid_i = 4'b1000;
    step();
    chk("fx_grant3", grant_b, 3);
    ifb.req_valid_i = 4'b0000;
    step();

    ifa.req_valid_i = 4'hF;
    ifa.out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_grant", grant_a, 64'(k % 4));
      chk("rr_odata", ifa.out_data_o, 64'(16'h00A0 + k % 4));
      chk("rr_rdy", ifa.req_ready_o, 64'(1) << (k % 4));
      step();
      ifa.srv_rsp_valid_i = 1'b1;
      ifa.srv_rsp_data_i  = 16'h00B0 + 16'(k);
      #1;
      e = '0;
      e[16*(k%4) +: 16] = 16'h00B0 + 16'(k);
      chk("rr_rval", ifa.rsp_valid_o, 64'(1) << (k % 4));
      chk("rr_rdata", ifa.rsp_data_o, e);
      chk("rr_rerr", ifa.rsp_err_o, 0);
      step();
      ifa.srv_rsp_valid_i = 1'b0;
    end

    ifa.req_valid_i = 4'b0100;
    ifa.out_ready_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_oval", ifa.out_valid_o, 1);
      chk("bp_odata", ifa.out_data_o, 16'h00A2);
      chk("bp_rdy", ifa.req_ready_o, 0);
      chk("bp_grant", grant_a, 2);
      step();
    end
    ifa.out_ready_i = 1'b1;
    #1;
    chk("bp_hs", ifa.req_ready_o, 4'b0100);
    step();
    ifa.out_ready_i = 1'b0;
    ifa.req_valid_i = 4'b0000;

    for (int c = 1; c < 8; c++) begin
      chk("to_quiet", ifa.rsp_valid_o, 0);
      chk("to_busy", busy_a, 1);
      step();
    end
    chk("to_rval", ifa.rsp_valid_o, 4'b0100);
    chk("to_rerr", ifa.rsp_err_o, 4'b0100);
    chk("to_rdata", ifa.rsp_data_o, 0);
    step();
    chk("to_idle", busy_a, 0);

    ifa.req_valid_i = 4'b1001;
    ifa.out_ready_i = 1'b1;
    step();
    chk("to_ptr", grant_a, 3);
    step();
    ifa.out_ready_i = 1'b0;
    for (int c = 1; c < 8; c++) begin
      chk("tie_quiet", ifa.rsp_valid_o, 0);
      step();
    end
    ifa.srv_rsp_valid_i = 1'b1;
    ifa.srv_rsp_data_i  = 16'hCAFE;
    #1;
    chk("tie_rval", ifa.rsp_valid_o, 4'b1000);
    chk("tie_rerr", ifa.rsp_err_o, 0);
    chk("tie_rdata", ifa.rsp_data_o, 64'hCAFE_0000_0000_0000);
    step();
    ifa.srv_rsp_valid_i = 1'b0;
    ifa.req_valid_i     = 4'b0000;

    ifa.req_valid_i = 4'b0001;
    step();
    chk("wd_grant", grant_a, 0);
    ifa.out_ready_i = 1'b1;
    ifa.req_valid_i = 4'b0000;
    #1;
    chk("wd_rdy", ifa.req_ready_o, 0);
    step();
    chk("wd_idle", busy_a, 0);
    ifa.out_ready_i = 1'b0;
    ifa.req_valid_i = 4'b0011;
    step();
    chk("wd_ptr", grant_a, 0);
    ifa.req_valid_i = 4'b0000;
    step();

    ifa.srv_rsp_valid_i = 1'b1;
    ifa.srv_rsp_data_i  = 16'h0077;
    #1;
    chk("ux_pulse", unexp_a, 1);
    chk("ux_rval", ifa.rsp_valid_o, 0);
    step();
    ifa.srv_rsp_valid_i = 1'b0;
    #1;
    chk("ux_clear", unexp_a, 0);

    ifa.req_valid_i = 4'b0010;
    ifa.out_ready_i = 1'b1;
    step();
    chk("pre_grant", grant_a, 1);
    step();
    ifa.srv_rsp_valid_i = 1'b1;
    ifa.srv_rsp_data_i  = 16'h0011;
    #1;
    chk("pre_rval", ifa.rsp_valid_o, 4'b0010);
    step();
    ifa.srv_rsp_valid_i = 1'b0;
    ifa.req_valid_i     = 4'b1000;
    step();
    chk("mr_grant", grant_a, 3);
    step();
    ifa.req_valid_i = 4'b0000;
    ifa.out_ready_i = 1'b0;
    chk("mr_wait", busy_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", busy_a, 0);
    chk("mr_rval", ifa.rsp_valid_o, 0);
    chk("mr_rerr", ifa.rsp_err_o, 0);
    chk("mr_grant0", grant_a, 0);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("mr_silent", ifa.rsp_valid_o, 0);
    end
    ifa.req_valid_i = 4'b0110;
    step();
    chk("mr_ptr", grant_a, 1);
    ifa.req_valid_i = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
